// File: rtl/flit_lock_ctrl_pkg.sv
// Shared flit-type and lock-state encodings for the per-port lock controller.
// Pure declarations; no logic, no latency, no flow control.
package flit_pkg;

  localparam int FLIT_TYPE_W = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    BODY      = 2'b00,
    HEAD      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED  = 2'd1,
    RELEASE = 2'd2
  } lock_state_e;

  function automatic logic opens_packet(input flit_type_e t);
    return (t == HEAD) || (t == HEAD_TAIL);
  endfunction

  function automatic logic closes_packet(input flit_type_e t);
    return (t == TAIL) || (t == HEAD_TAIL);
  endfunction

endpackage

// File: rtl/flit_lock_ctrl_pipe.sv
// One-entry valid/ready flit register: 1-cycle latency, 1 flit/cycle;
// holds its contents while out_ready_i is low, and free_o reports when it can load.
module flit_pipe_reg
  import flit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [DATA_W-1:0]      flit_i,
  input  logic [FLIT_TYPE_W-1:0] type_i,
  input  logic                   out_ready_i,
  output logic                   free_o,
  output logic                   out_valid_o,
  output logic [DATA_W-1:0]      out_flit_o,
  output logic [FLIT_TYPE_W-1:0] out_type_o
);

  logic                   valid_q, valid_d;
  logic [DATA_W-1:0]      flit_q, flit_d;
  logic [FLIT_TYPE_W-1:0] type_q, type_d;

  assign free_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    flit_d  = flit_q;
    type_d  = type_q;
    if (load_i) begin
      valid_d = 1'b1;
      flit_d  = flit_i;
      type_d  = type_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      flit_q  <= '0;
      type_q  <= '0;
    end else begin
      valid_q <= valid_d;
      flit_q  <= flit_d;
      type_q  <= type_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_flit_o  = flit_q;
  assign out_type_o  = type_q;

endmodule

// File: rtl/flit_lock_ctrl.sv
// Wormhole lock controller: forwards flits with 1-cycle latency, pulses lock_set/lock_reset for the hold latch.
// in_ready drops on downstream stall and during RELEASE; FLIT_LOCK_TIMEOUT_EN adds a LOCKED idle watchdog.
module flit_lock_ctrl
  import flit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_flit,
  input  logic [FLIT_TYPE_W-1:0] in_type,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_flit,
  output logic [FLIT_TYPE_W-1:0] out_type,
  output logic                   lock_set,
  output logic                   lock_reset,
  output logic                   locked,
  output logic                   err_proto,
  output logic                   err_timeout
);

  lock_state_e state_q, state_d;
  flit_type_e  ftype;
  logic        pipe_free;
  logic        hs;
  logic        legal;
  logic        fwd;
  logic        to_fire;
  logic        lock_set_q;
  logic        lock_reset_q;
  logic        err_proto_q;

  assign ftype    = flit_type_e'(in_type);
  assign in_ready = pipe_free && (state_q != RELEASE);
  assign hs       = in_valid && in_ready;

  always_comb begin
    legal = 1'b0;
    case (state_q)
      IDLE:    legal = opens_packet(ftype);
      LOCKED:  legal = (ftype == BODY) || (ftype == TAIL);
      default: legal = 1'b0;
    endcase
  end

  assign fwd = hs && legal;

  flit_pipe_reg #(
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (fwd),
    .flit_i      (in_flit),
    .type_i      (in_type),
    .out_ready_i (out_ready),
    .free_o      (pipe_free),
    .out_valid_o (out_valid),
    .out_flit_o  (out_flit),
    .out_type_o  (out_type)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fwd) state_d = closes_packet(ftype) ? RELEASE : LOCKED;
      end
      LOCKED: begin
        if ((fwd && ftype == TAIL) || to_fire) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // lock_reset resets to 1 so the latch clears for every cycle rst is held;
  // set only comes from IDLE and reset only from RELEASE, so they never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lock_set_q   <= 1'b0;
      lock_reset_q <= 1'b1;
      err_proto_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_set_q   <= fwd && (state_q == IDLE);
      lock_reset_q <= (state_q == RELEASE);
      err_proto_q  <= hs && !legal;
    end
  end

`ifdef FLIT_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_timeout_q;

  assign to_fire = (state_q == LOCKED) && !hs && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if ((state_q != LOCKED) || hs || to_fire) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      err_timeout_q <= to_fire;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign to_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign lock_set   = lock_set_q;
  assign lock_reset = lock_reset_q;
  assign err_proto  = err_proto_q;
  assign locked     = (state_q != IDLE);

endmodule

// File: tb/tb_flit_lock_ctrl.sv
module tb_flit_lock_ctrl;

`ifdef FLIT_LOCK_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 256;
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_flit;
  logic [1:0]  in_type;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_flit;
  logic [1:0]  out_type;
  logic        lock_set;
  logic        lock_reset;
  logic        locked;
  logic        err_proto;
  logic        err_timeout;

  flit_lock_ctrl #(
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_flit     (in_flit),
    .in_type     (in_type),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_flit    (out_flit),
    .out_type    (out_type),
    .lock_set    (lock_set),
    .lock_reset  (lock_reset),
    .locked      (locked),
    .err_proto   (err_proto),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a packet-open flag, a pending-release flag, an idle
  // counter and the contents of the one-entry output register.
  bit        m_known  = 1'b0;
  bit        m_in_pkt, m_release;
  int        m_idle;
  bit        m_out_vld;
  bit [31:0] m_out_flit;
  bit [1:0]  m_out_type;
  bit        m_lock_set, m_lock_reset, m_err_proto, m_err_to;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] t, input logic [31:0] f,
                     input logic ordy, input logic r);
    bit exp_rdy, hs, legal, fire;
    rst       = r;
    in_valid  = v;
    in_type   = t;
    in_flit   = f;
    out_ready = ordy;
    #1;
    exp_rdy = !m_release && (!m_out_vld || ordy);
    if (m_known) begin
      chk("in_ready",    in_ready,    exp_rdy);
      chk("out_valid",   out_valid,   m_out_vld);
      chk("out_flit",    out_flit,    m_out_flit);
      chk("out_type",    out_type,    m_out_type);
      chk("lock_set",    lock_set,    m_lock_set);
      chk("lock_reset",  lock_reset,  m_lock_reset);
      chk("locked",      locked,      m_in_pkt || m_release);
      chk("err_proto",   err_proto,   m_err_proto);
      chk("err_timeout", err_timeout, m_err_to);
      chk("set_reset_exclusive", lock_set && lock_reset, 1'b0);
    end
    if (r) begin
      m_known = 1'b1;  m_in_pkt = 1'b0;  m_release = 1'b0;  m_idle = 0;
      m_out_vld = 1'b0; m_out_flit = '0; m_out_type = '0;
      m_lock_set = 1'b0; m_lock_reset = 1'b1; m_err_proto = 1'b0; m_err_to = 1'b0;
    end else begin
      hs    = v && exp_rdy;
      legal = hs && (m_in_pkt ? (t == T_BODY || t == T_TAIL) : (t == T_HEAD || t == T_HT));
      fire  = 1'b0;
      if (TO_EN && m_in_pkt && !hs) begin
        m_idle++;
        if (m_idle == TO) fire = 1'b1;
      end else begin
        m_idle = 0;
      end
      m_lock_set   = legal && !m_in_pkt;
      m_lock_reset = m_release;
      m_err_proto  = hs && !legal;
      m_err_to     = fire;
      if (legal) begin
        m_out_vld = 1'b1; m_out_flit = f; m_out_type = t;
      end else if (ordy) begin
        m_out_vld = 1'b0;
      end
      m_release = (legal && (t == T_TAIL || t == T_HT)) || fire;
      if (legal && t == T_HEAD) m_in_pkt = 1'b1;
      else if ((legal && t == T_TAIL) || fire) m_in_pkt = 1'b0;
      if (!m_in_pkt) m_idle = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, T_BODY, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; in_type = '0; out_ready = 1'b1;
    @(negedge clk);

    // Reset held three cycles, then released.
    for (int i = 0; i < 3; i++) cyc(1'b0, T_BODY, 32'h0, 1'b1, 1'b1);
    chk("reset_lock_reset", lock_reset, 1'b1);
    chk("reset_out_valid",  out_valid,  1'b0);
    idle(2);

    // Four-flit packet at full rate.
    cyc(1'b1, T_HEAD, 32'hA0, 1'b1, 1'b0);
    cyc(1'b1, T_BODY, 32'hA1, 1'b1, 1'b0);
    cyc(1'b1, T_BODY, 32'hA2, 1'b1, 1'b0);
    cyc(1'b1, T_TAIL, 32'hA3, 1'b1, 1'b0);
    idle(3);

    // Single-flit packet.
    cyc(1'b1, T_HT, 32'h55, 1'b1, 1'b0);
    idle(3);

    // Orphan BODY in IDLE, then a stray HEAD inside a packet.
    cyc(1'b1, T_BODY, 32'h11, 1'b1, 1'b0);
    cyc(1'b1, T_HEAD, 32'h33, 1'b1, 1'b0);
    cyc(1'b1, T_HEAD, 32'h22, 1'b1, 1'b0);
    cyc(1'b1, T_TAIL, 32'h34, 1'b1, 1'b0);
    idle(3);

    // Downstream stall with the head held in the output register.
    cyc(1'b1, T_HEAD, 32'h40, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, T_BODY, 32'h41, 1'b0, 1'b0);
    cyc(1'b1, T_BODY, 32'h41, 1'b1, 1'b0);
    cyc(1'b1, T_TAIL, 32'h42, 1'b1, 1'b0);
    idle(3);

    // Reset in the middle of a packet with a flit still in flight.
    cyc(1'b1, T_HEAD, 32'h70, 1'b0, 1'b0);
    cyc(1'b0, T_BODY, 32'h0, 1'b0, 1'b1);
    idle(2);

`ifdef FLIT_LOCK_TIMEOUT_EN
    // Watchdog release, followed by an orphan TAIL.
    cyc(1'b1, T_HEAD, 32'h60, 1'b1, 1'b0);
    idle(TO + 3);
    cyc(1'b1, T_TAIL, 32'h61, 1'b1, 1'b0);
    idle(2);
`endif

    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
    end
    idle(TO + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
